alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational 8-bit ALU between two requesters. Each requester submits an operand pair and a 2-bit opcode through a valid/ready handshake. The block drives the ALU's A/B/Sel inputs from registered operands, waits a configurable settle time, captures Out/Zero, and returns the result on the owner's response channel. It sits between the two client datapaths and the single ALU instance.

---
 rtl/alu_arbiter.sv | 166 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin sequencer sharing one combinational 8-bit ALU between two requesters.
// Operands are registered onto the ALU, held for EXEC_CYCLES, and the result is returned to the owner.
module alu_arbiter #(
   parameter  int unsigned EXEC_CYCLES = 1,
   localparam int unsigned DW  = 8,
   localparam int unsigned OPW = 2,
   localparam int unsigned SW  = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   output logic           req0_ready,
   input  logic [DW-1:0]  req0_a,
   input  logic [DW-1:0]  req0_b,
   input  logic [OPW-1:0] req0_op,
   input  logic           req1_valid,
   output logic           req1_ready,
   input  logic [DW-1:0]  req1_a,
   input  logic [DW-1:0]  req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic [DW-1:0]  alu_a,
   output logic [DW-1:0]  alu_b,
   output logic [SW-1:0]  alu_sel,
   input  logic [DW-1:0]  alu_out,
   input  logic           alu_zero,
   output logic           rsp0_valid,
   input  logic           rsp0_ready,
   output logic [DW-1:0]  rsp0_data,
   output logic           rsp0_zero,
   output logic           rsp1_valid,
   input  logic           rsp1_ready,
   output logic [DW-1:0]  rsp1_data,
   output logic           rsp1_zero
);

   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q;
   logic           owner_q;
   logic           last_grant_q;
   logic           any_valid;
   logic           grant;
   logic           accept;
   logic           capture;
   logic           rsp_fire;
   logic [DW-1:0]  a_mux;
   logic [DW-1:0]  b_mux;
   logic [OPW-1:0] op_mux;

   // Opcode to ALU select: ADD, SUB, AND, OR
   function automatic logic [SW-1:0] map_sel(input logic [OPW-1:0] op);
      logic [SW-1:0] sel;
      case (op)
         2'b00:   sel = 4'b0010;
         2'b01:   sel = 4'b0110;
         2'b10:   sel = 4'b0000;
         default: sel = 4'b0001;
      endcase
      return sel;
   endfunction

   // On a tie the requester that was not served last wins
   always_comb begin
      any_valid = req0_valid | req1_valid;
      if (req0_valid && req1_valid) begin
         grant = ~last_grant_q;
      end else begin
         grant = ~req0_valid;
      end
      a_mux  = grant ? req1_a  : req0_a;
      b_mux  = grant ? req1_b  : req0_b;
      op_mux = grant ? req1_op : req0_op;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      accept     = 1'b0;
      capture    = 1'b0;
      rsp_fire   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = any_valid & ~grant;
            req1_ready = any_valid & grant;
            if (any_valid) begin
               accept  = 1'b1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_fire = owner_q ? rsp1_ready : rsp0_ready;
            if (rsp_fire) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ALU operand registers, settle counter and per-owner response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a        <= '0;
         alu_b        <= '0;
         alu_sel      <= '0;
         cnt_q        <= '0;
         owner_q      <= 1'b0;
         last_grant_q <= 1'b1;
         rsp0_valid   <= 1'b0;
         rsp0_data    <= '0;
         rsp0_zero    <= 1'b0;
         rsp1_valid   <= 1'b0;
         rsp1_data    <= '0;
         rsp1_zero    <= 1'b0;
      end else begin
         if (accept) begin
            alu_a   <= a_mux;
            alu_b   <= b_mux;
            alu_sel <= map_sel(op_mux);
            owner_q <= grant;
            cnt_q   <= CW'(EXEC_CYCLES - 1);
         end else if (state_q == EXEC && cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (capture) begin
            if (owner_q) begin
               rsp1_valid <= 1'b1;
               rsp1_data  <= alu_out;
               rsp1_zero  <= alu_zero;
            end else begin
               rsp0_valid <= 1'b1;
               rsp0_data  <= alu_out;
               rsp0_zero  <= alu_zero;
            end
         end
         if (rsp_fire) begin
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            last_grant_q <= owner_q;
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (1 and 4 settle cycles), a behavioural ALU,
// a response scoreboard, a vector table and hand-written corner sequences.
module tb_alu_arbiter;

   typedef struct packed {
      logic       own;
      logic [7:0] d;
      logic       z;
   } exp_t;

   typedef struct {
      bit         own;
      logic [7:0] a;
      logic [7:0] b;
      logic [1:0] op;
      logic [7:0] d;
      bit         z;
      logic [3:0] sel;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst1_n, rst4_n, sel4;
   logic       req0_valid, req1_valid;
   logic [7:0] req0_a, req0_b, req1_a, req1_b;
   logic [1:0] req0_op, req1_op;
   logic       rsp0_ready, rsp1_ready;

   logic [1:0] r0rdy_w, r1rdy_w, r0v_w, r1v_w, r0z_w, r1z_w, az_w;
   logic [7:0] aa_w [2];
   logic [7:0] ab_w [2];
   logic [7:0] ao_w [2];
   logic [7:0] r0d_w [2];
   logic [7:0] r1d_w [2];
   logic [3:0] as_w [2];

   logic       o_r0rdy, o_r1rdy, o_r0v, o_r1v, o_r0z, o_r1z, o_rst;
   logic [7:0] o_aa, o_ab, o_r0d, o_r1d;
   logic [3:0] o_as;

   int   tests = 0;
   int   fails = 0;
   exp_t q[$];
   int   glog[6];
   int   gi = 0;
   vec_t tbl[7];

   // Behavioural ALU shared by both instances
   function automatic logic [8:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] s);
      logic [7:0] o;
      case (s)
         4'b0010: o = a + b;
         4'b0110: o = a - b;
         4'b0000: o = a & b;
         4'b0001: o = a | b;
         default: o = 8'h00;
      endcase
      return {(o == 8'h00), o};
   endfunction

   assign {az_w[0], ao_w[0]} = alu_f(aa_w[0], ab_w[0], as_w[0]);
   assign {az_w[1], ao_w[1]} = alu_f(aa_w[1], ab_w[1], as_w[1]);

   alu_arbiter #(.EXEC_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst1_n),
      .req0_valid(req0_valid), .req0_ready(r0rdy_w[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(r1rdy_w[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(aa_w[0]), .alu_b(ab_w[0]), .alu_sel(as_w[0]), .alu_out(ao_w[0]), .alu_zero(az_w[0]),
      .rsp0_valid(r0v_w[0]), .rsp0_ready(rsp0_ready), .rsp0_data(r0d_w[0]), .rsp0_zero(r0z_w[0]),
      .rsp1_valid(r1v_w[0]), .rsp1_ready(rsp1_ready), .rsp1_data(r1d_w[0]), .rsp1_zero(r1z_w[0])
   );

   alu_arbiter #(.EXEC_CYCLES(4)) u_dut4 (
      .clk(clk), .rst_n(rst4_n),
      .req0_valid(req0_valid), .req0_ready(r0rdy_w[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(r1rdy_w[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .alu_a(aa_w[1]), .alu_b(ab_w[1]), .alu_sel(as_w[1]), .alu_out(ao_w[1]), .alu_zero(az_w[1]),
      .rsp0_valid(r0v_w[1]), .rsp0_ready(rsp0_ready), .rsp0_data(r0d_w[1]), .rsp0_zero(r0z_w[1]),
      .rsp1_valid(r1v_w[1]), .rsp1_ready(rsp1_ready), .rsp1_data(r1d_w[1]), .rsp1_zero(r1z_w[1])
   );

   // Outputs of whichever instance is currently under test
   always_comb begin
      o_r0rdy = r0rdy_w[sel4];
      o_r1rdy = r1rdy_w[sel4];
      o_r0v   = r0v_w[sel4];
      o_r1v   = r1v_w[sel4];
      o_r0z   = r0z_w[sel4];
      o_r1z   = r1z_w[sel4];
      o_aa    = aa_w[sel4];
      o_ab    = ab_w[sel4];
      o_as    = as_w[sel4];
      o_r0d   = r0d_w[sel4];
      o_r1d   = r1d_w[sel4];
      o_rst   = sel4 ? rst4_n : rst1_n;
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic pop_check(input logic own, input logic [7:0] d, input logic z);
      exp_t e;
      if (q.size() == 0) begin
         chk("rsp_unexpected", 1, 0);
      end else begin
         e = q.pop_front();
         chk("rsp_owner", int'(own), int'(e.own));
         chk("rsp_data", int'(d), int'(e.d));
         chk("rsp_zero", int'(z), int'(e.z));
      end
   endtask

   // Scoreboard: a response is consumed on every negedge where valid and ready are both high
   always @(negedge clk) begin
      if (o_rst) begin
         chk("one_ready", int'(o_r0rdy & o_r1rdy), 0);
         chk("one_rsp_valid", int'(o_r0v & o_r1v), 0);
         if (o_r0v && rsp0_ready) pop_check(1'b0, o_r0d, o_r0z);
         if (o_r1v && rsp1_ready) pop_check(1'b1, o_r1d, o_r1z);
      end
   end

   task automatic push_exp(input logic own, input logic [7:0] d, input logic z);
      exp_t e;
      e.own = own;
      e.d   = d;
      e.z   = z;
      q.push_back(e);
   endtask

   // Issue one request from posedge+1; lat >= 0 also measures accept-to-response edges
   task automatic send(input bit r, input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic [7:0] ed, input bit ez, input logic [3:0] es, input int lat);
      int n = 0;
      int l = 0;
      if (r) begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end
      @(negedge clk);
      while (!(r ? o_r1rdy : o_r0rdy) && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (!(r ? o_r1rdy : o_r0rdy)) begin
         chk("accept_timeout", 0, 1);
         req0_valid = 1'b0;
         req1_valid = 1'b0;
      end else begin
         push_exp(r, ed, ez);
         @(posedge clk); #1;
         if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
         @(negedge clk);
         chk("alu_sel", int'(o_as), int'(es));
         if (lat >= 0) begin
            while (!(r ? o_r1v : o_r0v) && l < 40) begin
               chk("alu_a_hold", int'(o_aa), int'(a));
               chk("alu_b_hold", int'(o_ab), int'(b));
               l++;
               @(negedge clk);
            end
            chk("latency", l, lat);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain", q.size(), 0);
      @(posedge clk); #1;
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_req0_ready"}, int'(o_r0rdy), 0);
      chk({nm, "_req1_ready"}, int'(o_r1rdy), 0);
      chk({nm, "_rsp0_valid"}, int'(o_r0v), 0);
      chk({nm, "_rsp1_valid"}, int'(o_r1v), 0);
      chk({nm, "_alu_sel"}, int'(o_as), 0);
      chk({nm, "_alu_a"}, int'(o_aa), 0);
      chk({nm, "_alu_b"}, int'(o_ab), 0);
      chk({nm, "_rsp0_data"}, int'(o_r0d), 0);
      chk({nm, "_rsp1_data"}, int'(o_r1d), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1, cyc, n;

      tbl[0] = '{1'b1, 8'h10, 8'h20, 2'b01, 8'hF0, 1'b0, 4'b0110};
      tbl[1] = '{1'b0, 8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 4'b0010};
      tbl[2] = '{1'b1, 8'hAA, 8'h55, 2'b10, 8'h00, 1'b1, 4'b0000};
      tbl[3] = '{1'b0, 8'hA0, 8'h05, 2'b11, 8'hA5, 1'b0, 4'b0001};
      tbl[4] = '{1'b1, 8'h00, 8'h01, 2'b01, 8'hFF, 1'b0, 4'b0110};
      tbl[5] = '{1'b0, 8'hFF, 8'h0F, 2'b10, 8'h0F, 1'b0, 4'b0000};
      tbl[6] = '{1'b0, 8'd7,  8'd9,  2'b00, 8'd16, 1'b0, 4'b0010};

      rst1_n = 1'b0; rst4_n = 1'b0; sel4 = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_a = '0; req0_b = '0; req0_op = '0;
      req1_a = '0; req1_b = '0; req1_op = '0;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst1_n = 1'b1;
      @(negedge clk);
      check_reset_vals("reset1");
      @(posedge clk); #1;

      // Single ADD on req0, one-cycle settle, response lasts one cycle
      send(1'b0, 8'd200, 8'd100, 2'b00, 8'd44, 1'b0, 4'b0010, 1);
      @(negedge clk);
      chk("add_rsp0_valid_after", int'(o_r0v), 0);
      chk("add_rsp1_valid", int'(o_r1v), 0);
      chk("add_rsp0_data_held", int'(o_r0d), 44);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++) begin
         send(tbl[i].own, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].d, tbl[i].z, tbl[i].sel, 1);
      end
      drain();

      // SUB to zero on req1 under response backpressure; req0 must wait
      rsp1_ready = 1'b0;
      send(1'b1, 8'h55, 8'h55, 2'b01, 8'h00, 1'b1, 4'b0110, 1);
      req0_a = 8'h01; req0_b = 8'h02; req0_op = 2'b00; req0_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_rsp1_valid", int'(o_r1v), 1);
         chk("bp_rsp1_data", int'(o_r1d), 0);
         chk("bp_rsp1_zero", int'(o_r1z), 1);
         chk("bp_req0_ready", int'(o_r0rdy), 0);
      end
      @(posedge clk); #1;
      rsp1_ready = 1'b1;
      req0_valid = 1'b0;
      drain();

      // Both valid continuously: grants must alternate starting with req0
      req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 2'b10;
      req1_a = 8'h0F; req1_b = 8'h30; req1_op = 2'b11;
      req0_valid = 1'b1; req1_valid = 1'b1;
      n0 = 0; n1 = 0; cyc = 0;
      while ((n0 < 3 || n1 < 3) && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (o_r0rdy) begin
            push_exp(1'b0, 8'h30, 1'b0);
            if (gi < 6) glog[gi] = 0;
            gi++; n0++;
         end
         if (o_r1rdy) begin
            push_exp(1'b1, 8'h3F, 1'b0);
            if (gi < 6) glog[gi] = 1;
            gi++; n1++;
         end
         @(posedge clk); #1;
         if (n0 >= 3) req0_valid = 1'b0;
         if (n1 >= 3) req1_valid = 1'b0;
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      chk("rr_count", gi, 6);
      for (int i = 0; i < 6; i++) chk("rr_order", glog[i], i % 2);
      drain();

      // Switch to the four-cycle settle instance
      rst1_n = 1'b0;
      sel4   = 1'b1;
      rst4_n = 1'b1;
      @(negedge clk);
      check_reset_vals("reset4");
      @(posedge clk); #1;
      send(1'b0, 8'd1, 8'd1, 2'b00, 8'd2, 1'b0, 4'b0010, 4);
      drain();

      // Reset during the second EXEC cycle aborts the operation
      send(1'b0, 8'd3, 8'd4, 2'b00, 8'd7, 1'b0, 4'b0010, -1);
      rst4_n = 1'b0;
      #1;
      check_reset_vals("abort");
      q.delete();
      @(negedge clk);
      @(negedge clk);
      rst4_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("abort_rsp0_valid", int'(o_r0v), 0);
         chk("abort_rsp1_valid", int'(o_r1v), 0);
      end
      @(posedge clk); #1;

      // After reset a tie goes to req0, then req1 is served
      req0_a = 8'h10; req0_b = 8'h20; req0_op = 2'b00;
      req1_a = 8'h09; req1_b = 8'h09; req1_op = 2'b01;
      req0_valid = 1'b1; req1_valid = 1'b1;
      @(negedge clk);
      chk("tie_req0_ready", int'(o_r0rdy), 1);
      chk("tie_req1_ready", int'(o_r1rdy), 0);
      if (o_r0rdy) push_exp(1'b0, 8'h30, 1'b0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!o_r1rdy && n < 64) begin
         @(negedge clk);
         n++;
      end
      chk("tie_req1_accept", int'(o_r1rdy), 1);
      if (o_r1rdy) push_exp(1'b1, 8'h00, 1'b1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
